// File: rtl/uart_tx_core_pkg.sv
// rtl/uart_tx_core_pkg.sv - shared state encoding and parity selectors for the UART transmitter
package uart_tx_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_core_serializer.sv
// rtl/uart_tx_core_serializer.sv - payload register and bit counter feeding the tx_out mux
module uart_tx_core_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  first,
  input  logic                  shift,
  output logic                  next_bit,
  output logic                  last_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         bit_cnt;

  // data_q[0] is always the bit currently on the line, so the next bit is data_q[1]
  assign next_bit = first ? data_q[0] : data_q[1];
  assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (first) begin
      bit_cnt <= '0;
    end else if (shift) begin
      data_q  <= data_q >> 1;
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmit framer: start, data LSB first, optional parity, stop bits
module uart_tx_core
  import uart_tx_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  tx_out
);

  tx_state_t state;
  logic      par_en_q;
  logic      parity_q;
  logic      stop_cnt;
  logic      last_stop;
  logic      accept;
  logic      ser_next_bit;
  logic      ser_last;

  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
  assign tx_ready  = (state == ST_IDLE) | ((state == ST_STOP) & last_stop);
  assign accept    = data_valid & tx_ready;

  uart_tx_core_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_data (p_data),
    .first     (state == ST_START),
    .shift     ((state == ST_DATA) & ~ser_last),
    .next_bit  (ser_next_bit),
    .last_bit  (ser_last)
  );

  // tx_out is loaded with the value of the state being entered, so it moves with state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      if (accept) begin
        par_en_q <= par_en;
        parity_q <= (^p_data) ^ (par_typ == PAR_ODD);
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_START;
            tx_out <= 1'b0;
            busy   <= 1'b1;
          end
        end
        ST_START: begin
          state  <= ST_DATA;
          tx_out <= ser_next_bit;
        end
        ST_DATA: begin
          if (ser_last) begin
            if (par_en_q) begin
              state  <= ST_PARITY;
              tx_out <= parity_q;
            end else begin
              state    <= ST_STOP;
              tx_out   <= 1'b1;
              stop_cnt <= 1'b0;
            end
          end else begin
            tx_out <= ser_next_bit;
          end
        end
        ST_PARITY: begin
          state    <= ST_STOP;
          tx_out   <= 1'b1;
          stop_cnt <= 1'b0;
        end
        ST_STOP: begin
          if (!last_stop) begin
            stop_cnt <= 1'b1;
          end else if (accept) begin
            state  <= ST_START;
            tx_out <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
